// File: rtl/udp_img_pkt_tx.sv
// udp_img_pkt_tx -- image packetiser feeding a UDP transmit engine.
//
// Pixel words are buffered in an internal FIFO. Once a full packet of payload
// is stored, tx_start_en pulses with a fixed tx_byte_num. The engine then pulls
// words with tx_req: a header word first, then PKT_WORDS payload words. After
// udp_tx_done, an inter-packet gap of IFG_CYCLES cycles follows.
//
// Optional build macro: IMG_CHKSUM_EN appends a trailer word that holds the
// modulo-2^32 sum of the header and payload words. It also adds 4 to tx_byte_num.
//
// Ports:
//   gmii_tx_clk  in   clock
//   rst          in   asynchronous active-high reset
//   pix_valid    in   pixel word valid
//   pix_data     in   [31:0] pixel word
//   pix_sof      in   first word of a frame (qualified by pix_valid)
//   pix_ready    out  FIFO can accept a word
//   tx_start_en  out  one-cycle packet start pulse
//   tx_byte_num  out  [15:0] packet byte count
//   tx_data      out  [31:0] word returned one cycle after each tx_req
//   tx_req       in   read strobe from the UDP engine
//   udp_tx_done  in   packet sent pulse
//   frame_cnt    out  [7:0] frames completed
//   sync_err     out  sticky: pix_sof arrived mid-frame
//   req_ovr      out  sticky: tx_req arrived outside the packet
//   fsm_state    out  [2:0] debug view of the output FSM (HUNT encodes as 0)
//
// Handshake: a pixel word transfers on every clock where pix_valid && pix_ready.
// pix_data and pix_sof are sampled only on those cycles.
module udp_img_pkt_tx #(
    parameter int PKT_WORDS      = 256,
    parameter int FIFO_AW        = 9,
    parameter int PKTS_PER_FRAME = 1800,
    parameter int IFG_CYCLES     = 16
) (
    input  logic        gmii_tx_clk,
    input  logic        rst,
    input  logic        pix_valid,
    input  logic [31:0] pix_data,
    input  logic        pix_sof,
    output logic        pix_ready,
    output logic        tx_start_en,
    output logic [15:0] tx_byte_num,
    output logic [31:0] tx_data,
    input  logic        tx_req,
    input  logic        udp_tx_done,
    output logic [7:0]  frame_cnt,
    output logic        sync_err,
    output logic        req_ovr,
    output logic [2:0]  fsm_state
);

    localparam int DEPTH       = 1 << FIFO_AW;
    localparam int FRAME_WORDS = PKT_WORDS * PKTS_PER_FRAME;
    localparam int IN_W        = $clog2(FRAME_WORDS + 1);
`ifdef IMG_CHKSUM_EN
    localparam int LAST_REQ    = PKT_WORDS + 1;
    localparam int BYTE_NUM    = 4 * PKT_WORDS + 8;
`else
    localparam int LAST_REQ    = PKT_WORDS;
    localparam int BYTE_NUM    = 4 * PKT_WORDS + 4;
`endif
    localparam int REQ_W       = $clog2(LAST_REQ + 1);
    localparam int GAP_W       = $clog2(IFG_CYCLES + 1);

    typedef enum logic [2:0] {HUNT, WAIT_FILL, START, SEND, WAIT_DONE, GAP} state_t;

    state_t             state_q, state_d;
    logic [31:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic [IN_W-1:0]    in_cnt_q;
    logic [REQ_W-1:0]   req_cnt_q, req_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [15:0]        pkt_idx_q;
    logic [7:0]         frame_cnt_q;
    logic               sync_err_q, req_ovr_q;
    logic [31:0]        tx_data_q;
    logic [15:0]        tx_byte_num_q;
`ifdef IMG_CHKSUM_EN
    logic [31:0]        sum_q;
`endif

    logic        fifo_full, wr_en, req_ok, hdr_req, pop;
    logic [31:0] header, rd_word;

    assign fifo_full = (count_q == (FIFO_AW+1)'(DEPTH));
    assign pix_ready = !fifo_full && !rst;
    // While hunting, only the sof word is stored. Once sync is held, every
    // accepted word is written.
    assign wr_en     = pix_valid && pix_ready && (state_q != HUNT || pix_sof);
    assign req_ok    = (state_q == SEND) && tx_req;
    assign hdr_req   = req_ok && (req_cnt_q == '0);
    assign pop       = req_ok && (req_cnt_q != '0) && (req_cnt_q <= REQ_W'(PKT_WORDS));
    assign header    = {frame_cnt_q, 8'h5A, pkt_idx_q};
    assign rd_word   = mem[rd_ptr_q];

    assign tx_start_en = (state_q == START);
    assign tx_byte_num = tx_byte_num_q;
    assign tx_data     = tx_data_q;
    assign frame_cnt   = frame_cnt_q;
    assign sync_err    = sync_err_q;
    assign req_ovr     = req_ovr_q;
    assign fsm_state   = state_q;

    always_comb begin
        state_d   = state_q;
        req_cnt_d = req_cnt_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            HUNT:      if (wr_en) state_d = WAIT_FILL;
            WAIT_FILL: if (count_q >= (FIFO_AW+1)'(PKT_WORDS)) state_d = START;
            START: begin
                req_cnt_d = '0;
                state_d   = SEND;
            end
            SEND: if (tx_req) begin
                req_cnt_d = req_cnt_q + 1'b1;
                if (req_cnt_q == REQ_W'(LAST_REQ)) state_d = WAIT_DONE;
            end
            WAIT_DONE: if (udp_tx_done) begin
                gap_cnt_d = '0;
                state_d   = GAP;
            end
            GAP: begin
                if (gap_cnt_q == GAP_W'(IFG_CYCLES - 1)) state_d = WAIT_FILL;
                else gap_cnt_d = gap_cnt_q + 1'b1;
            end
            default: state_d = HUNT;
        endcase
    end

    // Storage array has no reset. Clearing the pointers and count empties the FIFO.
    always_ff @(posedge gmii_tx_clk) begin
        if (wr_en) mem[wr_ptr_q] <= pix_data;
    end

    always_ff @(posedge gmii_tx_clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            in_cnt_q      <= '0;
            req_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            pkt_idx_q     <= '0;
            frame_cnt_q   <= '0;
            sync_err_q    <= 1'b0;
            req_ovr_q     <= 1'b0;
            tx_data_q     <= '0;
            tx_byte_num_q <= '0;
        end else begin
            state_q   <= state_d;
            req_cnt_q <= req_cnt_d;
            gap_cnt_q <= gap_cnt_d;

            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            if (wr_en) begin
                if (pix_sof) begin
                    // A sof word always starts a new frame count, even when it is early.
                    if (state_q != HUNT && in_cnt_q != '0) sync_err_q <= 1'b1;
                    in_cnt_q <= IN_W'(1);
                end else if (in_cnt_q == IN_W'(FRAME_WORDS - 1)) begin
                    in_cnt_q <= '0;
                end else begin
                    in_cnt_q <= in_cnt_q + 1'b1;
                end
            end

            if (tx_req && state_q != SEND) req_ovr_q <= 1'b1;

            if (hdr_req)  tx_data_q <= header;
            else if (pop) tx_data_q <= rd_word;
`ifdef IMG_CHKSUM_EN
            else if (req_ok) tx_data_q <= sum_q;
`endif

            if (state_q == START) tx_byte_num_q <= 16'(BYTE_NUM);

            if (state_q == WAIT_DONE && udp_tx_done) begin
                if (pkt_idx_q == 16'(PKTS_PER_FRAME - 1)) begin
                    pkt_idx_q   <= '0;
                    frame_cnt_q <= frame_cnt_q + 1'b1;
                end else begin
                    pkt_idx_q <= pkt_idx_q + 1'b1;
                end
            end
        end
    end

`ifdef IMG_CHKSUM_EN
    always_ff @(posedge gmii_tx_clk or posedge rst) begin
        if (rst)                   sum_q <= '0;
        else if (state_q == START) sum_q <= '0;
        else if (hdr_req)          sum_q <= sum_q + header;
        else if (pop)              sum_q <= sum_q + rd_word;
    end
`endif

endmodule

// File: doc/udp_img_pkt_tx.md
Name: udp_img_pkt_tx

Overview:
- Image packetiser directly upstream of the UDP transmit top.
- Buffers a 32-bit pixel-word stream in an internal FIFO. When one packet's worth of payload is stored, it pulses tx_start_en with a fixed tx_byte_num.
- Serves the UDP engine's tx_req read strobes: a header word first, then the payload words.
- Waits for udp_tx_done, then inserts an inter-packet gap before the next packet.

Parameters:
- PKT_WORDS, 256, payload words per packet (byte count = 4*PKT_WORDS + 4 for the header).
- FIFO_AW, 9, FIFO address width; depth 2**FIFO_AW must be >= PKT_WORDS.
- PKTS_PER_FRAME, 1800, packets per image frame; packet index wraps here.
- IFG_CYCLES, 16, idle cycles after udp_tx_done before the next tx_start_en.

Ports:
- gmii_tx_clk  in  1  single clock (GMII transmit clock domain).
- rst  in  1  asynchronous, active-high reset.
- pix_valid  in  1  pixel word valid.
- pix_data  in  32  pixel word.
- pix_sof  in  1  first word of a frame; qualified by pix_valid.
- pix_ready  out  1  FIFO can accept a word.
- tx_start_en  out  1  one-cycle packet start pulse to the UDP engine.
- tx_byte_num  out  16  packet byte count.
- tx_data  out  32  word returned for tx_req.
- tx_req  in  1  read strobe from the UDP engine.
- udp_tx_done  in  1  packet sent, one-cycle pulse.
- frame_cnt  out  8  frames completed (wraps at 255).
- sync_err  out  1  sticky flag: pix_sof arrived mid-frame.
- req_ovr  out  1  sticky flag: tx_req arrived beyond the packet length.

Behaviour:
- Reset: one clock gmii_tx_clk; reset rst is asynchronous and active-high. All state clears immediately on rst, including mid-packet; the FIFO empties.
- Values while rst is asserted: pix_ready=0, tx_start_en=0, tx_byte_num=0, tx_data=0, frame_cnt=0, sync_err=0, req_ovr=0; state=HUNT.
- Input side:
  - pix_ready = !fifo_full && !rst.
  - A word is accepted when pix_valid && pix_ready.
  - In HUNT, accepted words are discarded until the first pix_sof; that word is written and sync is gained.
  - Words are never dropped once sync is held.
  - in_cnt counts accepted words modulo PKT_WORDS*PKTS_PER_FRAME.
  - pix_sof with in_cnt != 0 sets sync_err, resets in_cnt to 1, and the word is still written.
- Output FSM:
  - WAIT_FILL: go to START when fifo_count >= PKT_WORDS.
  - START: tx_start_en=1 for exactly one cycle. tx_byte_num = 4*PKT_WORDS+4, held stable until udp_tx_done. Then go to SEND.
  - SEND: on each tx_req, tx_data updates on the next clock (latency 1).
    - First tx_req returns the header {frame_cnt[7:0], 8'h5A, pkt_idx[15:0]}.
    - The next PKT_WORDS tx_req strobes each pop one FIFO word in order.
    - After the last word, go to WAIT_DONE.
  - WAIT_DONE: on udp_tx_done, pkt_idx increments. At PKTS_PER_FRAME-1, pkt_idx wraps to 0 and frame_cnt increments. Then go to GAP.
  - GAP: counts IFG_CYCLES cycles, then returns to WAIT_FILL.
- tx_req outside SEND, or beyond the expected count: no FIFO pop, tx_data holds its value, req_ovr is set.
- udp_tx_done outside WAIT_DONE is ignored.
- A FIFO write and a read in the same cycle are both honoured; the count is unchanged.
- The FIFO never underflows in SEND, because a full packet is guaranteed before START.

Optional Feature:
- Macro IMG_CHKSUM_EN.
- When defined:
  - A trailer word is appended: the 32-bit modulo-2^32 sum of the header and all payload words of the packet.
  - tx_byte_num = 4*PKT_WORDS+8.
  - The trailer is served on tx_req number PKT_WORDS+2, before WAIT_DONE.
  - The running sum clears in START.
- When undefined: no trailer, no adder logic, and the byte count is as above.

Test Plan:
- Reset, then 300 words with pix_sof on the first and data = index. Expect tx_start_en pulsed once after word 256 is written, tx_byte_num=1028, header 0x005A0000, tx_data sequence 0..255 one cycle after each tx_req.
- 5 words before any pix_sof, then a pix_sof frame. Expect the pre-sof words discarded and the first payload word to be the sof word.
- Assert pix_sof at word 100 of a frame. Expect sync_err=1 sticky and the packet header index to continue unchanged.
- Small parameters (PKTS_PER_FRAME=2), 3 packets with udp_tx_done. Expect headers 0x005A0000, 0x005A0001, 0x015A0000; frame_cnt=1; at least 16 idle cycles between done and the next start.
- Issue 258 tx_req in one packet. Expect req_ovr=1, FIFO count reduced by exactly 256, tx_data held.
- Under IMG_CHKSUM_EN, payload all 0x00000001. Expect tx_byte_num=1032 and trailer = 0x005A0000 + 256 = 0x005A0100.
